// File: rtl/sms_sample_pulse_gen.sv
// sms_sample_pulse_gen
// Multi-channel sample-pulse generator. Each channel:
//   - synchronises an asynchronous AC trigger and a DC gate,
//   - turns the selected ac_in edge into a trigger while the gate is open,
//   - emits a fixed-width pulse followed by an optional holdoff,
//   - keeps a sticky overrun flag for triggers it had to drop.
// All outputs come straight from flops. Channels share nothing but the clock and reset.
module sms_sample_pulse_gen #(
  parameter int CHANNELS       = 4,
  parameter int PULSE_CYCLES   = 4,
  parameter int HOLDOFF_CYCLES = 2,
  parameter int SYNC_STAGES    = 2,
  parameter int EDGE_MODE      = 0,
  parameter int RETRIGGER      = 0
) (
  input  logic                x,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] ac_in,
  input  logic [CHANNELS-1:0] gate,
  input  logic [CHANNELS-1:0] clr_overrun,
  output logic [CHANNELS-1:0] pulse_out,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] overrun
);

  // The one down-counter serves both the pulse width and the holdoff,
  // so it is sized for whichever of the two is longer.
  localparam int MAX_CYCLES = (PULSE_CYCLES > HOLDOFF_CYCLES) ? PULSE_CYCLES : HOLDOFF_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PULSE   = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_e;

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : gChan
    logic [SYNC_STAGES-1:0] acSync_q;
    logic [SYNC_STAGES-1:0] acSync_d;
    logic [SYNC_STAGES-1:0] gateSync_q;
    logic [SYNC_STAGES-1:0] gateSync_d;
    logic                   acHist_q;
    logic                   acNow;
    logic                   gateNow;
    logic                   riseEvt;
    logic                   fallEvt;
    logic                   edgeEvt;
    logic                   trig;
    logic                   dropTrig;
    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   pulse_q;
    logic                   busy_q;
    logic                   overrun_q;

    // A single-stage chain has nothing to shift, so it just takes the raw input.
    if (SYNC_STAGES == 1) begin : gSyncShort
      assign acSync_d   = ac_in[ch];
      assign gateSync_d = gate[ch];
    end else begin : gSyncLong
      assign acSync_d   = {acSync_q[SYNC_STAGES-2:0], ac_in[ch]};
      assign gateSync_d = {gateSync_q[SYNC_STAGES-2:0], gate[ch]};
    end

    assign acNow   = acSync_q[SYNC_STAGES-1];
    assign gateNow = gateSync_q[SYNC_STAGES-1];

    // Synchronisers for ac_in and gate (equal depth) plus the history flop used for edge detection.
    always_ff @(posedge x or negedge rst_n) begin
      if (!rst_n) begin
        acSync_q   <= '0;
        gateSync_q <= '0;
        acHist_q   <= 1'b0;
      end else begin
        acSync_q   <= acSync_d;
        gateSync_q <= gateSync_d;
        acHist_q   <= acNow;
      end
    end

    assign riseEvt = acNow & ~acHist_q;
    assign fallEvt = ~acNow & acHist_q;

    // Pick which ac_in transition counts as an event.
    always_comb begin
      edgeEvt = riseEvt;
      case (EDGE_MODE)
        1:       edgeEvt = fallEvt;
        2:       edgeEvt = riseEvt | fallEvt;
        default: edgeEvt = riseEvt;
      endcase
    end

    // A closed gate swallows the event entirely; it never reaches the overrun logic.
    assign trig = edgeEvt & gateNow;

    // Triggers that the FSM cannot act on: any in holdoff, and those during a pulse
    // when retriggering is disabled.
    assign dropTrig = trig && (((state_q == ST_PULSE) && (RETRIGGER == 0)) ||
                               (state_q == ST_HOLDOFF));

    // Pulse/holdoff sequencer; pulse and busy are registered alongside the state.
    always_ff @(posedge x or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        pulse_q <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (trig) begin
              state_q <= ST_PULSE;
              cnt_q   <= PULSE_LOAD;
              pulse_q <= 1'b1;
              busy_q  <= 1'b1;
            end
          end
          ST_PULSE: begin
            if (trig && (RETRIGGER != 0)) begin
              cnt_q <= PULSE_LOAD;
            end else if (cnt_q != '0) begin
              cnt_q <= cnt_q - CNT_W'(1);
            end else if (HOLDOFF_CYCLES > 0) begin
              state_q <= ST_HOLDOFF;
              cnt_q   <= HOLD_LOAD;
              pulse_q <= 1'b0;
              busy_q  <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
              cnt_q   <= '0;
              pulse_q <= 1'b0;
              busy_q  <= 1'b0;
            end
          end
          ST_HOLDOFF: begin
            if (cnt_q == '0) begin
              state_q <= ST_IDLE;
              pulse_q <= 1'b0;
              busy_q  <= 1'b0;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
          default: begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end

    // Sticky overrun: a new drop beats a clear arriving on the same cycle.
    always_ff @(posedge x or negedge rst_n) begin
      if (!rst_n) begin
        overrun_q <= 1'b0;
      end else if (dropTrig) begin
        overrun_q <= 1'b1;
      end else if (clr_overrun[ch]) begin
        overrun_q <= 1'b0;
      end
    end

    assign pulse_out[ch] = pulse_q;
    assign busy[ch]      = busy_q;
    assign overrun[ch]   = overrun_q;
  end

endmodule

// File: tb/tb_sms_sample_pulse_gen.sv
// Testbench for sms_sample_pulse_gen. Two instances share the same inputs:
//   A: default parameters (rising edge, holdoff 2, no retrigger)
//   B: both edges, no holdoff, retrigger enabled
// The reference model tracks, per channel, the cycle at which the pulse and
// busy windows end, plus the sticky overrun bit.
module tb_sms_sample_pulse_gen;
  localparam int CH   = 4;
  localparam int SYNC = 2;
  localparam int PW   = 4;

  logic          x           = 1'b0;
  logic          rst_n       = 1'b0;
  logic [CH-1:0] ac_in       = '0;
  logic [CH-1:0] gate        = '0;
  logic [CH-1:0] clr_overrun = '0;
  logic [CH-1:0] pulseA, busyA, ovrA;
  logic [CH-1:0] pulseB, busyB, ovrB;

  int checks = 0;
  int errors = 0;

  int edgeN = 0;
  int pEnd[2][CH];
  int bEnd[2][CH];
  bit mOvr[2][CH];
  bit expP[2][CH];
  bit expB[2][CH];
  bit acH[CH][8];
  bit gtH[CH][8];

  always #5 x = ~x;

  sms_sample_pulse_gen u_dutA (
    .x(x), .rst_n(rst_n), .ac_in(ac_in), .gate(gate), .clr_overrun(clr_overrun),
    .pulse_out(pulseA), .busy(busyA), .overrun(ovrA)
  );

  sms_sample_pulse_gen #(
    .EDGE_MODE(2), .HOLDOFF_CYCLES(0), .RETRIGGER(1)
  ) u_dutB (
    .x(x), .rst_n(rst_n), .ac_in(ac_in), .gate(gate), .clr_overrun(clr_overrun),
    .pulse_out(pulseB), .busy(busyB), .overrun(ovrB)
  );

  // Model of one channel of one configuration at clock edge number edgeN.
  // A pulse accepted at edge n is high after edges n..n+P-1 and busy after n..n+P+H-1.
  function automatic void modelEdge(input int c, input int ch, input bit s, input bit h,
                                    input bit g, input bit clr);
    int  hold;
    int  mode;
    bit  ret;
    bit  evt;
    bit  drop;
    hold = (c == 0) ? 2 : 0;
    mode = (c == 0) ? 0 : 2;
    ret  = (c == 1);
    case (mode)
      0:       evt = s && !h;
      1:       evt = !s && h;
      default: evt = (s != h);
    endcase
    drop = 1'b0;
    if (evt && g) begin
      if ((edgeN - 1 >= bEnd[c][ch]) || (ret && (edgeN - 1 < pEnd[c][ch]))) begin
        pEnd[c][ch] = edgeN + PW;
        bEnd[c][ch] = edgeN + PW + hold;
      end else begin
        drop = 1'b1;
      end
    end
    if (drop) mOvr[c][ch] = 1'b1;
    else if (clr) mOvr[c][ch] = 1'b0;
    expP[c][ch] = (edgeN < pEnd[c][ch]);
    expB[c][ch] = (edgeN < bEnd[c][ch]);
  endfunction

  function automatic logic [CH-1:0] vecOf(input int c, input int kind);
    logic [CH-1:0] v;
    v = '0;
    for (int i = 0; i < CH; i++)
      v[i] = (kind == 0) ? expP[c][i] : (kind == 1) ? expB[c][i] : mOvr[c][i];
    return v;
  endfunction

  // Reference model: raw samples are delayed by the synchroniser depth, then judged.
  always @(posedge x or negedge rst_n) begin
    if (!rst_n) begin
      edgeN = 0;
      for (int ch = 0; ch < CH; ch++) begin
        for (int k = 0; k < 8; k++) begin
          acH[ch][k] = 1'b0;
          gtH[ch][k] = 1'b0;
        end
        for (int c = 0; c < 2; c++) begin
          pEnd[c][ch] = 0;
          bEnd[c][ch] = 0;
          mOvr[c][ch] = 1'b0;
          expP[c][ch] = 1'b0;
          expB[c][ch] = 1'b0;
        end
      end
    end else begin
      edgeN++;
      for (int ch = 0; ch < CH; ch++) begin
        for (int c = 0; c < 2; c++)
          modelEdge(c, ch, acH[ch][SYNC-1], acH[ch][SYNC], gtH[ch][SYNC-1], clr_overrun[ch]);
        for (int k = 7; k > 0; k--) begin
          acH[ch][k] = acH[ch][k-1];
          gtH[ch][k] = gtH[ch][k-1];
        end
        acH[ch][0] = ac_in[ch];
        gtH[ch][0] = gate[ch];
      end
    end
  end

  task automatic applyStimulus(input logic [CH-1:0] a, input logic [CH-1:0] g,
                               input logic [CH-1:0] c);
    ac_in       = a;
    gate        = g;
    clr_overrun = c;
  endtask

  task automatic settle(input int n);
    applyStimulus('0, '0, '0);
    repeat (n) @(negedge x);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    applyStimulus('0, '0, '0);
    repeat (2) @(negedge x);
    checks++;
    if ({pulseA, busyA, ovrA, pulseB, busyB, ovrB} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_hold got %h want 0", {pulseA, busyA, ovrA, pulseB, busyB, ovrB});
    end
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge x);
      checks++;
      if ({pulseA, busyA, ovrA, pulseB, busyB, ovrB} !== '0) begin
        errors++;
        $display("[TB] FAIL reset_idle step %0d got %h want 0", k, {pulseA, busyA, ovrA, pulseB, busyB, ovrB});
      end
    end
  endtask

  task automatic test_single_edge;
    int  riseEdge = -1;
    int  pCnt = 0, bCnt = 0, pCntB = 0, bCntB = 0;
    bit  other = 1'b0;
    settle(10);
    for (int k = 0; k < 14; k++) begin
      applyStimulus(4'b0001, 4'b1111, '0);
      @(negedge x);
      checks += 2;
      if ({pulseA, busyA, ovrA} !== {vecOf(0,0), vecOf(0,1), vecOf(0,2)}) begin
        errors++;
        $display("[TB] FAIL single_edge_A step %0d got %h want %h", k, {pulseA, busyA, ovrA}, {vecOf(0,0), vecOf(0,1), vecOf(0,2)});
      end
      if ({pulseB, busyB, ovrB} !== {vecOf(1,0), vecOf(1,1), vecOf(1,2)}) begin
        errors++;
        $display("[TB] FAIL single_edge_B step %0d got %h want %h", k, {pulseB, busyB, ovrB}, {vecOf(1,0), vecOf(1,1), vecOf(1,2)});
      end
      if (pulseA[0] && riseEdge < 0) riseEdge = k + 1;
      pCnt  += int'(pulseA[0]);
      bCnt  += int'(busyA[0]);
      pCntB += int'(pulseB[0]);
      bCntB += int'(busyB[0]);
      if ((pulseA[3:1] | busyA[3:1] | pulseB[3:1] | busyB[3:1]) != 3'b000) other = 1'b1;
    end
    checks += 6;
    if (riseEdge !== 3) begin errors++; $display("[TB] FAIL single_rise_edge got %0d want 3", riseEdge); end
    if (pCnt !== 4)     begin errors++; $display("[TB] FAIL single_width_A got %0d want 4", pCnt); end
    if (bCnt !== 6)     begin errors++; $display("[TB] FAIL single_busy_A got %0d want 6", bCnt); end
    if (pCntB !== 4)    begin errors++; $display("[TB] FAIL single_width_B got %0d want 4", pCntB); end
    if (bCntB !== 4)    begin errors++; $display("[TB] FAIL single_busy_B got %0d want 4", bCntB); end
    if (other !== 1'b0) begin errors++; $display("[TB] FAIL single_other_channels got %0d want 0", other); end
  endtask

  task automatic test_gate_closed;
    bit seen = 1'b0;
    settle(10);
    for (int k = 0; k < 14; k++) begin
      applyStimulus(4'b0001, (k < 4) ? 4'b0000 : 4'b0001, '0);
      @(negedge x);
      checks += 2;
      if ({pulseA, busyA, ovrA} !== {vecOf(0,0), vecOf(0,1), vecOf(0,2)}) begin
        errors++;
        $display("[TB] FAIL gate_closed_A step %0d got %h want %h", k, {pulseA, busyA, ovrA}, {vecOf(0,0), vecOf(0,1), vecOf(0,2)});
      end
      if ({pulseB, busyB, ovrB} !== {vecOf(1,0), vecOf(1,1), vecOf(1,2)}) begin
        errors++;
        $display("[TB] FAIL gate_closed_B step %0d got %h want %h", k, {pulseB, busyB, ovrB}, {vecOf(1,0), vecOf(1,1), vecOf(1,2)});
      end
      if (pulseA[0] | pulseB[0] | ovrA[0] | ovrB[0]) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("[TB] FAIL gate_closed_activity got %0d want 0", seen); end
  endtask

  task automatic test_overrun;
    int pCnt = 0;
    bit ovrK4 = 1'b1, ovrK5 = 1'b0;
    settle(10);
    for (int k = 0; k < 12; k++) begin
      applyStimulus((k == 1) ? 4'b0000 : 4'b0001, 4'b0001, '0);
      @(negedge x);
      checks += 2;
      if ({pulseA, busyA, ovrA} !== {vecOf(0,0), vecOf(0,1), vecOf(0,2)}) begin
        errors++;
        $display("[TB] FAIL overrun_A step %0d got %h want %h", k, {pulseA, busyA, ovrA}, {vecOf(0,0), vecOf(0,1), vecOf(0,2)});
      end
      if ({pulseB, busyB, ovrB} !== {vecOf(1,0), vecOf(1,1), vecOf(1,2)}) begin
        errors++;
        $display("[TB] FAIL overrun_B step %0d got %h want %h", k, {pulseB, busyB, ovrB}, {vecOf(1,0), vecOf(1,1), vecOf(1,2)});
      end
      pCnt += int'(pulseA[0]);
    end
    checks += 2;
    if (pCnt !== 4)      begin errors++; $display("[TB] FAIL overrun_width got %0d want 4", pCnt); end
    if (ovrA[0] !== 1'b1) begin errors++; $display("[TB] FAIL overrun_set got %0d want 1", ovrA[0]); end
    applyStimulus(4'b0001, 4'b0001, 4'b0001);
    @(negedge x);
    applyStimulus(4'b0001, 4'b0001, '0);
    @(negedge x);
    checks++;
    if (ovrA[0] !== 1'b0) begin errors++; $display("[TB] FAIL overrun_clear got %0d want 0", ovrA[0]); end
    for (int k = 0; k < 12; k++) begin
      applyStimulus((k == 0 || k == 2) ? 4'b0000 : 4'b0001, 4'b0001, (k == 5) ? 4'b0001 : 4'b0000);
      @(negedge x);
      checks += 2;
      if ({pulseA, busyA, ovrA} !== {vecOf(0,0), vecOf(0,1), vecOf(0,2)}) begin
        errors++;
        $display("[TB] FAIL overrun_clr_A step %0d got %h want %h", k, {pulseA, busyA, ovrA}, {vecOf(0,0), vecOf(0,1), vecOf(0,2)});
      end
      if ({pulseB, busyB, ovrB} !== {vecOf(1,0), vecOf(1,1), vecOf(1,2)}) begin
        errors++;
        $display("[TB] FAIL overrun_clr_B step %0d got %h want %h", k, {pulseB, busyB, ovrB}, {vecOf(1,0), vecOf(1,1), vecOf(1,2)});
      end
      if (k == 4) ovrK4 = ovrA[0];
      if (k == 5) ovrK5 = ovrA[0];
    end
    checks += 2;
    if (ovrK4 !== 1'b0) begin errors++; $display("[TB] FAIL overrun_before_drop got %0d want 0", ovrK4); end
    if (ovrK5 !== 1'b1) begin errors++; $display("[TB] FAIL overrun_set_beats_clear got %0d want 1", ovrK5); end
  endtask

  task automatic test_retrigger;
    int pCnt = 0, rises = 0;
    bit prev = 1'b0, ovrSeen = 1'b0;
    settle(10);
    for (int k = 0; k < 18; k++) begin
      applyStimulus((k < 3 || k >= 6) ? 4'b0010 : 4'b0000, 4'b0010, '0);
      @(negedge x);
      checks += 2;
      if ({pulseA, busyA, ovrA} !== {vecOf(0,0), vecOf(0,1), vecOf(0,2)}) begin
        errors++;
        $display("[TB] FAIL retrigger_A step %0d got %h want %h", k, {pulseA, busyA, ovrA}, {vecOf(0,0), vecOf(0,1), vecOf(0,2)});
      end
      if ({pulseB, busyB, ovrB} !== {vecOf(1,0), vecOf(1,1), vecOf(1,2)}) begin
        errors++;
        $display("[TB] FAIL retrigger_B step %0d got %h want %h", k, {pulseB, busyB, ovrB}, {vecOf(1,0), vecOf(1,1), vecOf(1,2)});
      end
      pCnt += int'(pulseB[1]);
      if (pulseB[1] && !prev) rises++;
      prev = pulseB[1];
      if (ovrB[1]) ovrSeen = 1'b1;
    end
    checks += 3;
    if (pCnt !== 10)       begin errors++; $display("[TB] FAIL retrigger_width got %0d want 10", pCnt); end
    if (rises !== 1)       begin errors++; $display("[TB] FAIL retrigger_rises got %0d want 1", rises); end
    if (ovrSeen !== 1'b0)  begin errors++; $display("[TB] FAIL retrigger_overrun got %0d want 0", ovrSeen); end
  endtask

  task automatic test_square_wave;
    int  pCnt = 0, rises = 0, run = 0, maxRun = 0;
    bit  prev = 1'b0;
    logic lvl;
    settle(10);
    for (int k = 0; k < 48; k++) begin
      lvl = (k < 40) && (((k / 5) % 2) == 0);
      applyStimulus({1'b0, lvl, 2'b00}, 4'b0100, '0);
      @(negedge x);
      checks += 2;
      if ({pulseA, busyA, ovrA} !== {vecOf(0,0), vecOf(0,1), vecOf(0,2)}) begin
        errors++;
        $display("[TB] FAIL square_A step %0d got %h want %h", k, {pulseA, busyA, ovrA}, {vecOf(0,0), vecOf(0,1), vecOf(0,2)});
      end
      if ({pulseB, busyB, ovrB} !== {vecOf(1,0), vecOf(1,1), vecOf(1,2)}) begin
        errors++;
        $display("[TB] FAIL square_B step %0d got %h want %h", k, {pulseB, busyB, ovrB}, {vecOf(1,0), vecOf(1,1), vecOf(1,2)});
      end
      pCnt += int'(pulseB[2]);
      if (pulseB[2] && !prev) rises++;
      prev = pulseB[2];
      run = busyB[2] ? run + 1 : 0;
      if (run > maxRun) maxRun = run;
    end
    checks += 3;
    if (rises !== 8)  begin errors++; $display("[TB] FAIL square_pulses got %0d want 8", rises); end
    if (pCnt !== 32)  begin errors++; $display("[TB] FAIL square_high_cycles got %0d want 32", pCnt); end
    if (maxRun > 4)   begin errors++; $display("[TB] FAIL square_busy_run got %0d want <=4", maxRun); end
  endtask

  task automatic test_random;
    logic [CH-1:0] lvl = '0;
    logic [CH-1:0] g, c;
    settle(10);
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(0, 3) == 0) lvl[i] = ~lvl[i];
        g[i] = ($urandom_range(0, 4) != 0);
        c[i] = ($urandom_range(0, 15) == 0);
      end
      applyStimulus(lvl, g, c);
      @(negedge x);
      checks += 2;
      if ({pulseA, busyA, ovrA} !== {vecOf(0,0), vecOf(0,1), vecOf(0,2)}) begin
        errors++;
        $display("[TB] FAIL random_A step %0d got %h want %h", k, {pulseA, busyA, ovrA}, {vecOf(0,0), vecOf(0,1), vecOf(0,2)});
      end
      if ({pulseB, busyB, ovrB} !== {vecOf(1,0), vecOf(1,1), vecOf(1,2)}) begin
        errors++;
        $display("[TB] FAIL random_B step %0d got %h want %h", k, {pulseB, busyB, ovrB}, {vecOf(1,0), vecOf(1,1), vecOf(1,2)});
      end
    end
  endtask

  task automatic test_midpulse_reset;
    int risesA = 0, risesB = 0;
    bit prevA = 1'b0, prevB = 1'b0;
    settle(10);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(4'b1111, 4'b1111, '0);
      @(negedge x);
      checks += 2;
      if ({pulseA, busyA, ovrA} !== {vecOf(0,0), vecOf(0,1), vecOf(0,2)}) begin
        errors++;
        $display("[TB] FAIL pre_reset_A step %0d got %h want %h", k, {pulseA, busyA, ovrA}, {vecOf(0,0), vecOf(0,1), vecOf(0,2)});
      end
      if ({pulseB, busyB, ovrB} !== {vecOf(1,0), vecOf(1,1), vecOf(1,2)}) begin
        errors++;
        $display("[TB] FAIL pre_reset_B step %0d got %h want %h", k, {pulseB, busyB, ovrB}, {vecOf(1,0), vecOf(1,1), vecOf(1,2)});
      end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({pulseA, busyA, ovrA, pulseB, busyB, ovrB} !== '0) begin
      errors++;
      $display("[TB] FAIL async_reset got %h want 0", {pulseA, busyA, ovrA, pulseB, busyB, ovrB});
    end
    @(negedge x);
    rst_n = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(negedge x);
      checks += 2;
      if ({pulseA, busyA, ovrA} !== {vecOf(0,0), vecOf(0,1), vecOf(0,2)}) begin
        errors++;
        $display("[TB] FAIL post_reset_A step %0d got %h want %h", k, {pulseA, busyA, ovrA}, {vecOf(0,0), vecOf(0,1), vecOf(0,2)});
      end
      if ({pulseB, busyB, ovrB} !== {vecOf(1,0), vecOf(1,1), vecOf(1,2)}) begin
        errors++;
        $display("[TB] FAIL post_reset_B step %0d got %h want %h", k, {pulseB, busyB, ovrB}, {vecOf(1,0), vecOf(1,1), vecOf(1,2)});
      end
      if (pulseA[0] && !prevA) risesA++;
      if (pulseB[0] && !prevB) risesB++;
      prevA = pulseA[0];
      prevB = pulseB[0];
    end
    checks += 2;
    if (risesA !== 1) begin errors++; $display("[TB] FAIL post_reset_pulses_A got %0d want 1", risesA); end
    if (risesB !== 1) begin errors++; $display("[TB] FAIL post_reset_pulses_B got %0d want 1", risesB); end
  endtask

  initial begin
    test_reset();
    test_single_edge();
    test_gate_closed();
    test_overrun();
    test_retrigger();
    test_square_wave();
    test_random();
    test_midpulse_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
